// File: rtl/bottle_rain.sv
// Multi-slot falling-object game element: N_OBJ independent objects spawned at
// pseudo-random X, falling at a level-dependent speed, with catch/miss tracking.
module bottle_rain #(
  parameter int unsigned N_OBJ         = 4,
  parameter int unsigned SIZE          = 16,
  parameter logic [11:0] ELEMENT_COLOR = 12'hFA0,
  parameter int unsigned X_RANGE       = 624,
  parameter int unsigned Y_MAX         = 464,
  parameter int unsigned DELAY         = 50000000,
  parameter int unsigned VY_INIT       = 2,
  parameter int unsigned VY_MAX        = 8,
  parameter int unsigned LEVEL_STEP    = 10,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pause,
  input  logic             frame_tick,
  input  logic [9:0]       x,
  input  logic [9:0]       y,
  input  logic             collision,
  output logic             print,
  output logic [11:0]      pixel,
  output logic [N_OBJ-1:0] active_mask,
  output logic [15:0]      caught,
  output logic [15:0]      missed,
  output logic [3:0]       level
);

  localparam int unsigned CNT_W  = (DELAY > 1) ? $clog2(DELAY) : 1;
  localparam int unsigned STEP_W = (LEVEL_STEP > 1) ? $clog2(LEVEL_STEP) : 1;

  typedef enum logic {
    S_IDLE,
    S_FALLING
  } slot_state_t;

  slot_state_t       state_q [N_OBJ];
  slot_state_t       state_d [N_OBJ];
  logic [9:0]        ox_q    [N_OBJ];
  logic [9:0]        ox_d    [N_OBJ];
  logic [9:0]        oy_q    [N_OBJ];
  logic [9:0]        oy_d    [N_OBJ];

  logic [CNT_W-1:0]  spawn_cnt_q, spawn_cnt_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [15:0]       caught_q, caught_d;
  logic [15:0]       missed_q, missed_d;
  logic [3:0]        level_q, level_d;
  logic [STEP_W-1:0] step_cnt_q, step_cnt_d;

  logic [N_OBJ-1:0]  hit;
  logic [N_OBJ-1:0]  catch_vec;
  logic [N_OBJ-1:0]  spawn_vec;
  logic [N_OBJ-1:0]  miss_vec;
  logic              catch_en;
  logic              spawn_req;
  logic [9:0]        spawn_x;
  logic [10:0]       vy;
  logic [3:0]        n_miss;

  // Rendering from registered state only
  always_comb begin
    hit = '0;
    for (int unsigned i = 0; i < N_OBJ; i++) begin
      hit[i] = (state_q[i] == S_FALLING)
            && (x >= ox_q[i]) && ({1'b0, x} < ({1'b0, ox_q[i]} + 11'(SIZE)))
            && (y >= oy_q[i]) && ({1'b0, y} < ({1'b0, oy_q[i]} + 11'(SIZE)));
    end
  end

  assign print     = |hit;
  assign pixel     = print ? ELEMENT_COLOR : '0;
  assign catch_en  = collision & print & ~pause;
  assign spawn_req = ~pause && (spawn_cnt_q == CNT_W'(DELAY - 1));

  // Lowest-index hit takes the catch; lowest-index idle slot takes the spawn
  always_comb begin
    logic hit_found;
    logic idle_found;
    catch_vec  = '0;
    spawn_vec  = '0;
    hit_found  = 1'b0;
    idle_found = 1'b0;
    for (int unsigned i = 0; i < N_OBJ; i++) begin
      if (hit[i] && !hit_found) begin
        catch_vec[i] = catch_en;
        hit_found    = 1'b1;
      end
      if ((state_q[i] == S_IDLE) && !idle_found) begin
        spawn_vec[i] = spawn_req;
        idle_found   = 1'b1;
      end
    end
  end

  always_comb begin
    logic [10:0] raw_x;
    raw_x   = {1'b0, lfsr_q[9:0]};
    spawn_x = (raw_x < 11'(X_RANGE)) ? raw_x[9:0] : 10'(raw_x - 11'(X_RANGE));
  end

  always_comb begin
    logic [10:0] vy_raw;
    vy_raw = 11'(VY_INIT) + 11'(level_q);
    vy     = (vy_raw > 11'(VY_MAX)) ? 11'(VY_MAX) : vy_raw;
  end

  // A caught slot is freed before motion is considered, so catch beats miss
  always_comb begin
    logic [10:0] ny;
    miss_vec = '0;
    for (int unsigned i = 0; i < N_OBJ; i++) begin
      state_d[i] = state_q[i];
      ox_d[i]    = ox_q[i];
      oy_d[i]    = oy_q[i];
      ny         = {1'b0, oy_q[i]} + vy;
      if (!pause) begin
        if (state_q[i] == S_FALLING) begin
          if (catch_vec[i]) begin
            state_d[i] = S_IDLE;
          end else if (frame_tick) begin
            if (ny >= 11'(Y_MAX)) begin
              state_d[i]  = S_IDLE;
              miss_vec[i] = 1'b1;
            end else begin
              oy_d[i] = ny[9:0];
            end
          end
        end else if (spawn_vec[i]) begin
          state_d[i] = S_FALLING;
          ox_d[i]    = spawn_x;
          oy_d[i]    = '0;
        end
      end
    end
  end

  always_comb begin
    logic [16:0] miss_sum;
    lfsr_d      = lfsr_q;
    spawn_cnt_d = spawn_cnt_q;
    caught_d    = caught_q;
    level_d     = level_q;
    step_cnt_d  = step_cnt_q;
    n_miss      = '0;
    for (int unsigned i = 0; i < N_OBJ; i++) begin
      n_miss = n_miss + 4'(miss_vec[i]);
    end
    miss_sum = {1'b0, missed_q} + 17'(n_miss);
    missed_d = miss_sum[16] ? '1 : miss_sum[15:0];
    if (!pause) begin
      lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      spawn_cnt_d = spawn_req ? '0 : spawn_cnt_q + CNT_W'(1);
    end
    // Level advances only on real catches, so a saturated caught stops levelling
    if (catch_en && (caught_q != '1)) begin
      caught_d = caught_q + 16'd1;
      if (step_cnt_q == STEP_W'(LEVEL_STEP - 1)) begin
        step_cnt_d = '0;
        if (level_q != '1) level_d = level_q + 4'd1;
      end else begin
        step_cnt_d = step_cnt_q + STEP_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < N_OBJ; i++) begin
        state_q[i] <= S_IDLE;
        ox_q[i]    <= '0;
        oy_q[i]    <= '0;
      end
      spawn_cnt_q <= '0;
      lfsr_q      <= LFSR_SEED;
      caught_q    <= '0;
      missed_q    <= '0;
      level_q     <= '0;
      step_cnt_q  <= '0;
    end else begin
      for (int unsigned i = 0; i < N_OBJ; i++) begin
        state_q[i] <= state_d[i];
        ox_q[i]    <= ox_d[i];
        oy_q[i]    <= oy_d[i];
      end
      spawn_cnt_q <= spawn_cnt_d;
      lfsr_q      <= lfsr_d;
      caught_q    <= caught_d;
      missed_q    <= missed_d;
      level_q     <= level_d;
      step_cnt_q  <= step_cnt_d;
    end
  end

  always_comb begin
    active_mask = '0;
    for (int unsigned i = 0; i < N_OBJ; i++) begin
      active_mask[i] = (state_q[i] == S_FALLING);
    end
  end

  assign caught = caught_q;
  assign missed = missed_q;
  assign level  = level_q;

endmodule

// File: tb/tb_bottle_rain.sv
// Directed bench for bottle_rain: spawn, motion, miss, catch, slot exhaustion,
// levelling, pause and mid-fall reset, observed through ports and pixel probes.
module tb_bottle_rain;

  localparam int unsigned N_OBJ      = 2;
  localparam int unsigned SIZE       = 16;
  localparam int unsigned X_RANGE    = 624;
  localparam int unsigned Y_MAX      = 40;
  localparam int unsigned DELAY      = 100;
  localparam int unsigned VY_INIT    = 2;
  localparam int unsigned VY_MAX     = 8;
  localparam int unsigned LEVEL_STEP = 2;
  localparam logic [15:0] SEED       = 16'hACE1;
  localparam logic [11:0] COLOR      = 12'hFA0;

  logic             clk;
  logic             reset;
  logic             pause;
  logic             frame_tick;
  logic [9:0]       x;
  logic [9:0]       y;
  logic             collision;
  logic             print;
  logic [11:0]      pixel;
  logic [N_OBJ-1:0] active_mask;
  logic [15:0]      caught;
  logic [15:0]      missed;
  logic [3:0]       level;

  bottle_rain #(
    .N_OBJ(N_OBJ), .SIZE(SIZE), .ELEMENT_COLOR(COLOR), .X_RANGE(X_RANGE),
    .Y_MAX(Y_MAX), .DELAY(DELAY), .VY_INIT(VY_INIT), .VY_MAX(VY_MAX),
    .LEVEL_STEP(LEVEL_STEP), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .reset(reset), .pause(pause), .frame_tick(frame_tick),
    .x(x), .y(y), .collision(collision), .print(print), .pixel(pixel),
    .active_mask(active_mask), .caught(caught), .missed(missed), .level(level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference for spawn timing and spawn X
  logic [15:0] lfsr_m;
  int unsigned cnt_m;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic logic [9:0] map_x(input logic [15:0] l);
    int unsigned v;
    v = int'(l[9:0]);
    return (v < X_RANGE) ? 10'(v) : 10'(v - X_RANGE);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      cnt_m  <= 0;
      lfsr_m <= SEED;
    end else if (!pause) begin
      cnt_m  <= (cnt_m == DELAY - 1) ? 0 : cnt_m + 1;
      lfsr_m <= lfsr_step(lfsr_m);
    end
  end

  task automatic to_spawn(output logic [9:0] sx);
    int unsigned guard;
    guard = 0;
    while (cnt_m != DELAY - 1 && guard < 2 * DELAY) begin
      @(negedge clk);
      guard++;
    end
    check("spawn_wait", (guard < 2 * DELAY) ? 32'd1 : 32'd0, 32'd1);
    sx = map_x(lfsr_m);
    @(negedge clk);
  endtask

  task automatic probe(input string tag, input logic [9:0] xx, input logic [9:0] yy,
                       input logic exp);
    @(negedge clk);
    x = xx;
    y = yy;
    #1;
    check(tag, print, exp);
  endtask

  task automatic ftick(input int unsigned n);
    frame_tick = 1'b1;
    repeat (n) @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic catch_at(input logic [9:0] xx, input logic [9:0] yy);
    x = xx;
    y = yy;
    collision = 1'b1;
    @(negedge clk);
    collision = 1'b0;
  endtask

  logic [9:0] ox0, ox1, h, a, b, c, d, e, s, f, g, r;
  int unsigned hits;
  int unsigned exp_caught;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; pause = 1'b0; frame_tick = 1'b0; x = '0; y = '0; collision = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mask", active_mask, 0);
    check("rst_caught", caught, 0);
    check("rst_missed", missed, 0);
    check("rst_level", level, 0);
    check("rst_print", print, 0);
    reset = 1'b0;

    // First spawn DELAY clocks after reset, then motion at vy=2
    to_spawn(ox0);
    check("spawn_mask", active_mask, 2'b01);
    probe("spawn_tl", ox0, 0, 1'b1);
    check("pixel_on", pixel, COLOR);
    probe("spawn_br", ox0 + 10'd15, 10'd15, 1'b1);
    probe("spawn_xr", ox0 + 10'd16, 0, 1'b0);
    probe("spawn_yb", ox0, 10'd16, 1'b0);
    check("pixel_off", pixel, 0);
    ftick(1);
    probe("mv_y1", ox0, 10'd1, 1'b0);
    probe("mv_y2", ox0, 10'd2, 1'b1);
    probe("mv_y17", ox0, 10'd17, 1'b1);
    probe("mv_y18", ox0, 10'd18, 1'b0);

    // Miss boundary: oy=38 still falling, oy=40 reaches Y_MAX
    ftick(18);
    check("pre_miss_mask", active_mask, 2'b01);
    probe("pre_miss_y38", ox0, 10'd38, 1'b1);
    probe("pre_miss_y37", ox0, 10'd37, 1'b0);
    ftick(1);
    check("miss_mask", active_mask, 2'b00);
    check("miss_missed", missed, 1);
    check("miss_caught", caught, 0);

    // Scan with collision held: exactly one visible pixel, one catch
    to_spawn(ox1);
    check("scan_mask0", active_mask, 2'b01);
    hits = 0;
    for (int unsigned yy = 0; yy < 3; yy++) begin
      for (int unsigned xx = 0; xx < 18; xx++) begin
        @(negedge clk);
        x = 10'(int'(ox1) + xx);
        y = 10'(yy);
        collision = 1'b1;
        #1;
        if (print) hits++;
      end
    end
    @(negedge clk);
    collision = 1'b0;
    check("scan_hits", hits, 1);
    check("scan_caught", caught, 1);
    check("scan_mask", active_mask, 2'b00);
    check("scan_missed", missed, 1);
    check("scan_level", level, 0);
    exp_caught = 1;

    // Catch and miss plus frame_tick on one edge: catch wins
    to_spawn(h);
    ftick(19);
    x = h; y = 10'd38; collision = 1'b1; frame_tick = 1'b1;
    @(negedge clk);
    collision = 1'b0; frame_tick = 1'b0;
    exp_caught++;
    check("cm_caught", caught, 2);
    check("cm_missed", missed, 1);
    check("cm_level", level, 1);
    check("cm_mask", active_mask, 2'b00);

    // Fill both slots, third spawn dropped, free slot1 and refill it
    to_spawn(a);
    to_spawn(b);
    check("full_mask", active_mask, 2'b11);
    to_spawn(c);
    check("drop_mask", active_mask, 2'b11);
    if (a != b) begin
      catch_at((b < a) ? b : b + 10'd15, 0);
      exp_caught++;
      check("free1_mask", active_mask, 2'b01);
      check("free1_caught", caught, exp_caught);
      to_spawn(d);
      check("refill_mask", active_mask, 2'b11);
      probe("refill_px", d, 0, 1'b1);
    end else begin
      d = b;
    end

    // Level 1 -> vy=3 for both slots
    ftick(1);
    probe("vy3_y2", a, 10'd2, 1'b0);
    probe("vy3_y3", a, 10'd3, 1'b1);
    catch_at(a, 10'd3);
    exp_caught++;
    catch_at(d, 10'd3);
    exp_caught++;
    check("lv2_mask", active_mask, 2'b00);
    check("lv2_caught", caught, exp_caught);
    check("lv2_level", level, 2);

    to_spawn(e);
    ftick(1);
    probe("vy4_y3", e, 10'd3, 1'b0);
    probe("vy4_y4", e, 10'd4, 1'b1);
    catch_at(e, 10'd4);
    exp_caught++;
    while (exp_caught < 14) begin
      to_spawn(s);
      catch_at(s, 0);
      exp_caught++;
    end
    check("lv7_caught", caught, 14);
    check("lv7_level", level, 7);

    // Level 7: VY_INIT+7=9 clamps to VY_MAX=8
    to_spawn(f);
    ftick(1);
    probe("vy8_y7", f, 10'd7, 1'b0);
    probe("vy8_y8", f, 10'd8, 1'b1);

    // Pause with frame_tick and collision on a visible pixel
    pause = 1'b1; frame_tick = 1'b1; collision = 1'b1; x = f; y = 10'd8;
    repeat (500) @(negedge clk);
    #1;
    check("pause_print", print, 1);
    check("pause_caught", caught, 14);
    check("pause_missed", missed, 1);
    check("pause_level", level, 7);
    check("pause_mask", active_mask, 2'b01);
    frame_tick = 1'b0; collision = 1'b0; pause = 1'b0;
    to_spawn(g);
    check("post_pause_mask", active_mask, 2'b11);
    probe("post_pause_g", g, 0, 1'b1);
    probe("post_pause_f7", f, 10'd7, 1'b0);
    probe("post_pause_f8", f, 10'd8, 1'b1);

    // Reset mid-fall
    reset = 1'b1;
    @(negedge clk);
    x = f; y = 10'd8;
    #1;
    check("rst2_mask", active_mask, 0);
    check("rst2_caught", caught, 0);
    check("rst2_missed", missed, 0);
    check("rst2_level", level, 0);
    check("rst2_print", print, 0);
    reset = 1'b0;
    to_spawn(r);
    check("rst2_spawn_mask", active_mask, 2'b01);
    probe("rst2_spawn_px", r, 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
